time_counter: RTL

- Timekeeping stage directly downstream of the 1 Hz divider.
- Consumes the divider's square wave (one rising edge per second, same clk_in domain) and maintains a BCD hh:mm:ss count.
- Supports pause, manual minute/hour increment and validated time load.
- Feeds the display/scan stage and the hourly chime.

---
 rtl/time_counter_pkg.sv | 31 +++
 rtl/time_counter_bcd2_counter.sv | 41 ++++
 rtl/time_counter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/time_counter_pkg.sv
// Shared constants, state encoding and BCD helpers for the hh:mm:ss timekeeping stage.
package time_counter_pkg;

   localparam logic [7:0] SEC_MAX     = 8'h59;
   localparam logic [7:0] MIN_MAX     = 8'h59;
   localparam logic [7:0] H24_MAX     = 8'h23;
   localparam logic [7:0] H12_MAX     = 8'h12;
   localparam logic [7:0] H12_MIN     = 8'h01;
   localparam logic [7:0] H12_PM_EDGE = 8'h11;
   localparam logic [7:0] BCD_ZERO    = 8'h00;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_SYNC = 1'b1
   } tc_state_e;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      logic [7:0] r;
      if (v[3:0] >= 4'd9) begin
         r = {v[7:4] + 4'd1, 4'd0};
      end else begin
         r = {v[7:4], v[3:0] + 4'd1};
      end
      return r;
   endfunction

   function automatic logic bcd_valid(input logic [7:0] v);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
   endfunction

endpackage

// File: rtl/time_counter_bcd2_counter.sv
// Two-digit BCD counter with a configurable top value, wrap target and reset value.
module bcd2_counter
   import time_counter_pkg::*;
#(
   parameter logic [7:0] MAX     = SEC_MAX,
   parameter logic [7:0] WRAP_TO = BCD_ZERO,
   parameter logic [7:0] RST_VAL = BCD_ZERO
) (
   input  logic       clk_in,
   input  logic       rst,
   input  logic       inc,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic [7:0] value,
   output logic       carry
);

   logic [7:0] value_q;
   logic [7:0] value_d;

   always_comb begin
      value_d = value_q;
      if (load) begin
         value_d = load_val;
      end else if (inc) begin
         value_d = (value_q == MAX) ? WRAP_TO : bcd_inc(value_q);
      end
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         value_q <= RST_VAL;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;
   assign carry = inc & ~load & (value_q == MAX);

endmodule

// File: rtl/time_counter.sv
// BCD hh:mm:ss timekeeper fed by the 1 Hz divider; handles pause, manual
// minute/hour stepping, validated time load and the hourly chime strobe.
module time_counter
   import time_counter_pkg::*;
#(
   parameter bit MODE12   = 1'b0,
   parameter bit CHIME_EN = 1'b1
) (
   input  logic       clk_in,
   input  logic       rst,
   input  logic       sec_in,
   input  logic       hold,
   input  logic       inc_min,
   input  logic       inc_hour,
   input  logic       load,
   input  logic [7:0] set_hour,
   input  logic [7:0] set_min,
   input  logic       set_pm,
   output logic [7:0] hour_bcd,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic       pm,
   output logic       hour_strobe,
   output logic       load_err
);

   localparam logic [7:0] HOUR_MAX  = MODE12 ? H12_MAX : H24_MAX;
   localparam logic [7:0] HOUR_WRAP = MODE12 ? H12_MIN : BCD_ZERO;
   localparam logic [7:0] HOUR_RST  = MODE12 ? H12_MAX : BCD_ZERO;

   tc_state_e state_q, state_d;
   logic      sec_prev_q, sec_prev_d;
   logic      tick_q, tick_d;
   logic      pending_q, pending_d;
   logic      pm_q, pm_d;
   logic      strobe_q, strobe_d;
   logic      load_err_q, load_err_d;

   logic       hour_ok, load_ok, cnt_load;
   logic       do_inc_hour, do_inc_min, do_tick;
   logic       sec_inc, min_inc, hour_inc;
   logic       sec_carry, min_carry, hour_carry_unused;
   logic [7:0] sec_val, min_val, hour_val;

   always_comb begin
      if (MODE12) begin
         hour_ok = (set_hour >= H12_MIN) && (set_hour <= H12_MAX);
      end else begin
         hour_ok = (set_hour <= H24_MAX);
      end
   end

   assign load_ok  = bcd_valid(set_hour) && bcd_valid(set_min) && (set_min <= MIN_MAX) && hour_ok;
   assign cnt_load = load & load_ok;

   // Event priority: load > inc_hour > inc_min > tick (live or deferred).
   assign do_inc_hour = inc_hour & ~load;
   assign do_inc_min  = inc_min & ~inc_hour & ~load;
   assign do_tick     = ~load & ~inc_hour & ~inc_min & (tick_q | pending_q);

   assign sec_inc  = do_tick;
   assign min_inc  = do_inc_min | sec_carry;
   assign hour_inc = do_inc_hour | (sec_carry & min_carry);

   bcd2_counter #(
      .MAX     (SEC_MAX),
      .WRAP_TO (BCD_ZERO),
      .RST_VAL (BCD_ZERO)
   ) u_sec (
      .clk_in   (clk_in),
      .rst      (rst),
      .inc      (sec_inc),
      .load     (cnt_load),
      .load_val (BCD_ZERO),
      .value    (sec_val),
      .carry    (sec_carry)
   );

   bcd2_counter #(
      .MAX     (MIN_MAX),
      .WRAP_TO (BCD_ZERO),
      .RST_VAL (BCD_ZERO)
   ) u_min (
      .clk_in   (clk_in),
      .rst      (rst),
      .inc      (min_inc),
      .load     (cnt_load),
      .load_val (set_min),
      .value    (min_val),
      .carry    (min_carry)
   );

   // Day rollover has no consumer, so the hour carry is left dangling.
   bcd2_counter #(
      .MAX     (HOUR_MAX),
      .WRAP_TO (HOUR_WRAP),
      .RST_VAL (HOUR_RST)
   ) u_hour (
      .clk_in   (clk_in),
      .rst      (rst),
      .inc      (hour_inc),
      .load     (cnt_load),
      .load_val (set_hour),
      .value    (hour_val),
      .carry    (hour_carry_unused)
   );

   always_comb begin
      state_d    = ST_RUN;
      sec_prev_d = sec_in;
      tick_d     = 1'b0;
      pending_d  = pending_q;
      pm_d       = pm_q;
      load_err_d = load & ~load_ok;
      strobe_d   = CHIME_EN & sec_carry & min_carry;

      // SYNC resynchronises the edge detector so a level-high sec_in is not an edge.
      if ((state_q == ST_RUN) && !cnt_load) begin
         tick_d = sec_in & ~sec_prev_q & ~hold;
      end

      if (cnt_load) begin
         state_d   = ST_SYNC;
         pending_d = 1'b0;
         pm_d      = MODE12 ? set_pm : 1'b0;
      end else begin
         if (do_inc_hour || do_inc_min) begin
            pending_d = pending_q | tick_q;
         end else if (do_tick) begin
            pending_d = pending_q & tick_q;
         end
         if (MODE12 && hour_inc && (hour_val == H12_PM_EDGE)) begin
            pm_d = ~pm_q;
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q    <= ST_SYNC;
         sec_prev_q <= 1'b0;
         tick_q     <= 1'b0;
         pending_q  <= 1'b0;
         pm_q       <= 1'b0;
         strobe_q   <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sec_prev_q <= sec_prev_d;
         tick_q     <= tick_d;
         pending_q  <= pending_d;
         pm_q       <= pm_d;
         strobe_q   <= strobe_d;
         load_err_q <= load_err_d;
      end
   end

   assign hour_bcd    = hour_val;
   assign min_bcd     = min_val;
   assign sec_bcd     = sec_val;
   assign pm          = pm_q;
   assign hour_strobe = strobe_q;
   assign load_err    = load_err_q;

endmodule
